// File: rtl/led_drv_pkg.sv
// Shared constants for the LED pattern path: default chain geometry,
// serial timing and the frame-state encoding used by led_shift_driver.
package led_drv_pkg;

  localparam int DEF_N_LEDS       = 12;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_LATCH_CYCLES = 2;

  typedef logic [1:0] state_t;

  // Frame states; the unused code 2'd3 falls back to ST_IDLE.
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_LATCH = 2'd2;

  // Clock cycles from accepting a pattern until the block is ready again.
  function automatic int frame_cycles(input int n_leds, input int clk_div, input int latch_cycles);
    return n_leds * 2 * clk_div + latch_cycles;
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Half-period timer for the serial clock. Counts CLK_DIV cycles per phase,
// flags the last cycle of each phase and toggles the sr_clk level.
module sr_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half_done,
  output logic phase_hi
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] phase_cnt_r;
  logic          phase_hi_r;
  logic          half_done_s;

  // Last cycle of the current half-period while the timer is running.
  always_comb begin
    half_done_s = 1'b0;
    if (enable && (phase_cnt_r == TERM_CNT)) begin
      half_done_s = 1'b1;
    end else begin
      half_done_s = 1'b0;
    end
  end

  // Phase counter and sr_clk level; clear restarts a low phase from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_r <= {CW{1'b0}};
      phase_hi_r  <= 1'b0;
    end else if (clear) begin
      phase_cnt_r <= {CW{1'b0}};
      phase_hi_r  <= 1'b0;
    end else if (half_done_s) begin
      phase_cnt_r <= {CW{1'b0}};
      phase_hi_r  <= ~phase_hi_r;
    end else if (enable) begin
      phase_cnt_r <= phase_cnt_r + CW'(1);
    end else begin
      phase_cnt_r <= phase_cnt_r;
    end
  end

  assign half_done = half_done_s;
  assign phase_hi  = phase_hi_r;

endmodule

// File: rtl/led_shift_driver.sv
// Snapshots a packed LED pattern and shifts it MSB-first into a 74HC595-style
// chain (sr_data / sr_clk), then pulses sr_latch to update the outputs.
module led_shift_driver
  import led_drv_pkg::*;
#(
  parameter int N_LEDS         = DEF_N_LEDS,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
  parameter int SEND_ON_CHANGE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              pattern_valid,
  output logic              pattern_ready,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              sr_latch,
  output logic              busy,
  output logic [7:0]        frames_sent
);

  localparam int BCW = $clog2(N_LEDS + 1);
  localparam int LCW = $clog2(LATCH_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(N_LEDS - 1);
  localparam logic [LCW-1:0] LATCH_END = LCW'(LATCH_CYCLES - 1);
  localparam logic           ALWAYS_SEND = (SEND_ON_CHANGE == 0);

  state_t            state_r;
  logic [N_LEDS-1:0] shreg_r;
  logic [N_LEDS-1:0] last_sent_r;
  logic              first_flag_r;
  logic [BCW-1:0]    bit_cnt_r;
  logic [LCW-1:0]    latch_cnt_r;
  logic              ready_r;
  logic              busy_r;
  logic              sr_data_r;
  logic              sr_latch_r;
  logic [7:0]        frames_r;

  logic              accept_s;
  logic              high_done_s;
  logic              last_bit_s;
  logic              latch_done_s;
  logic              timer_clear_s;
  logic              timer_en_s;
  logic              half_done_s;
  logic              phase_hi_s;
  logic [N_LEDS-1:0] shreg_next_s;

  sr_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear_s),
    .enable    (timer_en_s),
    .half_done (half_done_s),
    .phase_hi  (phase_hi_s)
  );

  // Accept decision and per-state event strobes.
  always_comb begin
    accept_s      = 1'b0;
    high_done_s   = 1'b0;
    last_bit_s    = 1'b0;
    latch_done_s  = 1'b0;
    timer_en_s    = 1'b0;
    timer_clear_s = 1'b0;
    shreg_next_s  = shreg_r << 1;
    if ((state_r == ST_IDLE) && ready_r && pattern_valid &&
        (ALWAYS_SEND || first_flag_r || (pattern_in != last_sent_r))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == ST_SHIFT) begin
      timer_en_s  = 1'b1;
      high_done_s = half_done_s & phase_hi_s;
    end else begin
      timer_en_s  = 1'b0;
      high_done_s = 1'b0;
    end
    if (bit_cnt_r == LAST_BIT) begin
      last_bit_s = 1'b1;
    end else begin
      last_bit_s = 1'b0;
    end
    if ((state_r == ST_LATCH) && (latch_cnt_r == LATCH_END)) begin
      latch_done_s = 1'b1;
    end else begin
      latch_done_s = 1'b0;
    end
    // Restart the timer from a low phase on accept and when leaving SHIFT.
    timer_clear_s = accept_s | (high_done_s & last_bit_s);
  end

  // Frame FSM: snapshot on accept, shift out bit by bit, latch, then count the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {N_LEDS{1'b0}};
      last_sent_r  <= {N_LEDS{1'b0}};
      first_flag_r <= 1'b1;
      bit_cnt_r    <= {BCW{1'b0}};
      latch_cnt_r  <= {LCW{1'b0}};
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      sr_data_r    <= 1'b0;
      sr_latch_r   <= 1'b0;
      frames_r     <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r      <= ST_SHIFT;
            shreg_r      <= pattern_in;
            last_sent_r  <= pattern_in;
            first_flag_r <= 1'b0;
            bit_cnt_r    <= {BCW{1'b0}};
            sr_data_r    <= pattern_in[N_LEDS-1];
            ready_r      <= 1'b0;
            busy_r       <= 1'b1;
          end else begin
            // Also raises ready on the first edge after reset release.
            ready_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (high_done_s && last_bit_s) begin
            state_r     <= ST_LATCH;
            bit_cnt_r   <= {BCW{1'b0}};
            latch_cnt_r <= {LCW{1'b0}};
            sr_latch_r  <= 1'b1;
          end else if (high_done_s) begin
            // Falling sr_clk edge: present the next bit.
            bit_cnt_r <= bit_cnt_r + BCW'(1);
            shreg_r   <= shreg_next_s;
            sr_data_r <= shreg_next_s[N_LEDS-1];
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        ST_LATCH: begin
          if (latch_done_s) begin
            state_r     <= ST_IDLE;
            latch_cnt_r <= {LCW{1'b0}};
            sr_latch_r  <= 1'b0;
            sr_data_r   <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            frames_r    <= frames_r + 8'd1;
          end else begin
            latch_cnt_r <= latch_cnt_r + LCW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          bit_cnt_r   <= {BCW{1'b0}};
          latch_cnt_r <= {LCW{1'b0}};
          sr_latch_r  <= 1'b0;
          sr_data_r   <= 1'b0;
          busy_r      <= 1'b0;
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign pattern_ready = ready_r;
  assign sr_data       = sr_data_r;
  assign sr_clk        = phase_hi_s;
  assign sr_latch      = sr_latch_r;
  assign busy          = busy_r;
  assign frames_sent   = frames_r;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: a scoreboard of expected serial bits
// (pushed when a pattern is offered, popped on each sr_clk rise) plus
// timing, latch and frame-counter checks. A second instance covers
// SEND_ON_CHANGE=0 and the 8-bit frame counter wrap.
module tb_led_shift_driver;

  localparam int N     = 12;
  localparam int CD    = 4;
  localparam int LC    = 2;
  localparam int FRAME = N * 2 * CD + LC;   // 98

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] pattern_in = 12'h000;
  logic         pattern_valid = 1'b0;
  logic         pattern_ready, sr_data, sr_clk, sr_latch, busy;
  logic [7:0]   frames_sent;

  logic [N-1:0] pin0 = 12'h000;
  logic         val0 = 1'b0;
  logic         ready0, sdata0, sclk0, slatch0, busy0;
  logic [7:0]   frames0;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int latch_pulses = 0;
  int lat_run = 0;
  logic sclk_prev = 1'b0;
  logic exp_bit;
  logic expq[$];

  always #5 clk = ~clk;

  led_shift_driver #(.N_LEDS(N), .CLK_DIV(CD), .LATCH_CYCLES(LC), .SEND_ON_CHANGE(1)) dut (
    .clk(clk), .reset(reset), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready), .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .busy(busy), .frames_sent(frames_sent)
  );

  led_shift_driver #(.N_LEDS(N), .CLK_DIV(CD), .LATCH_CYCLES(LC), .SEND_ON_CHANGE(0)) dut0 (
    .clk(clk), .reset(reset), .pattern_in(pin0), .pattern_valid(val0),
    .pattern_ready(ready0), .sr_data(sdata0), .sr_clk(sclk0), .sr_latch(slatch0),
    .busy(busy0), .frames_sent(frames0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input logic [N-1:0] p);
    for (int i = N - 1; i >= 0; i--) expq.push_back(p[i]);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (pattern_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Serial monitor: pop one expected bit per sr_clk rise, measure latch pulses.
  always @(negedge clk) begin
    if (reset == 1'b0) begin
      expq.delete();
      sclk_prev = 1'b0;
      lat_run = 0;
    end else begin
      if (sr_clk && !sclk_prev) begin
        rises++;
        if (expq.size() > 0) begin
          exp_bit = expq.pop_front();
          chk("serial_bit", sr_data, exp_bit);
        end else begin
          chk("bit_queue_depth", expq.size(), 1);
        end
      end
      sclk_prev = sr_clk;
      if (sr_latch) begin
        lat_run++;
      end else if (lat_run != 0) begin
        chk("latch_width", lat_run, LC);
        latch_pulses++;
        lat_run = 0;
      end
    end
  end

  initial begin
    int n;
    int base;
    int lp;
    logic [N-1:0] snap;

    // 1: reset held 5 cycles, outputs all zero, ready on first edge after release.
    repeat (5) @(negedge clk);
    chk("rst_ready", pattern_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sr_data", sr_data, 0);
    chk("rst_sr_clk", sr_clk, 0);
    chk("rst_sr_latch", sr_latch, 0);
    chk("rst_frames", frames_sent, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", pattern_ready, 1);
    chk("idle_busy", busy, 0);

    // 2: single frame of 12'hA5C.
    pattern_in = 12'hA5C; pattern_valid = 1'b1; push_bits(12'hA5C);
    @(negedge clk);
    pattern_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", pattern_ready, 0);
    chk("accept_msb", sr_data, 1);
    wait_ready(n);
    chk("frame_time", n, FRAME);
    @(negedge clk);
    chk("rises_frame1", rises, 12);
    chk("latch_pulses_1", latch_pulses, 1);
    chk("frames_1", frames_sent, 1);
    chk("queue_empty_1", expq.size(), 0);

    // 3: constant 12'h0F0 held valid for 400 cycles sends once; a change sends again.
    pattern_in = 12'h0F0; pattern_valid = 1'b1; push_bits(12'h0F0);
    repeat (400) @(negedge clk);
    chk("hold_frames", frames_sent, 2);
    chk("hold_rises", rises, 24);
    chk("hold_ready", pattern_ready, 1);
    pattern_in = 12'h00F; push_bits(12'h00F);
    @(negedge clk);
    chk("change_accept_busy", busy, 1);
    wait_ready(n);
    chk("change_frame_time", n, FRAME);
    pattern_valid = 1'b0;
    @(negedge clk);
    chk("frames_3", frames_sent, 3);
    chk("latch_pulses_3", latch_pulses, 3);
    chk("queue_empty_3", expq.size(), 0);

    // 4: pattern_in blinks every cycle during the frame; only the snapshot is sent.
    pattern_in = 12'h3C6; pattern_valid = 1'b1; push_bits(12'h3C6);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      pattern_valid = 1'b0;
      if (pattern_ready === 1'b1) break;
      pattern_in = ~pattern_in;
    end
    chk("blink_frame_time", n, FRAME + 1);
    @(negedge clk);
    chk("frames_4", frames_sent, 4);
    chk("queue_empty_4", expq.size(), 0);

    // 5: reset mid-frame, outputs drop asynchronously, no latch; same pattern re-sent.
    snap = 12'h5A3;
    pattern_in = snap; pattern_valid = 1'b1; push_bits(snap);
    @(negedge clk);
    pattern_valid = 1'b0;
    base = rises - 1;
    n = 0;
    while (rises < base + 6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    lp = latch_pulses;
    #1 reset = 1'b0;
    #1;
    chk("async_sr_clk", sr_clk, 0);
    chk("async_sr_data", sr_data, 0);
    chk("async_sr_latch", sr_latch, 0);
    chk("async_busy", busy, 0);
    chk("async_frames", frames_sent, 0);
    repeat (3) @(negedge clk);
    chk("no_latch_in_abort", latch_pulses, lp);
    reset = 1'b1;
    push_bits(snap);
    @(negedge clk);
    chk("ready_after_abort", pattern_ready, 1);
    pattern_valid = 1'b1;
    @(negedge clk);
    pattern_valid = 1'b0;
    chk("resend_busy", busy, 1);
    wait_ready(n);
    chk("resend_frame_time", n, FRAME);
    @(negedge clk);
    chk("resend_latch", latch_pulses, lp + 1);
    chk("resend_frames", frames_sent, 1);
    chk("queue_empty_5", expq.size(), 0);

    // 6: SEND_ON_CHANGE=0, valid tied high: 256 back-to-back frames of one pattern.
    pin0 = 12'h123; val0 = 1'b1;
    for (int f = 0; f < 256; f++) begin
      n = 0;
      while (busy0 !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_idle_gap", n, 1);
      n = 0;
      while (busy0 === 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_frame_len", n, FRAME);
      if (f == 254) chk("frames_255", frames0, 255);
    end
    val0 = 1'b0;
    chk("frames_wrap", frames0, 0);
    chk("wrap_ready", ready0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
